// File: rtl/i2c_cfg_sequencer_if.sv
// Handshake bundle between the config sequencer, its table ROM and the byte-level I2C write engine.
// The master side is the sequencer; the slave side is the engine plus ROM.
interface i2c_cfg_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] tbl_addr;
    logic [23:0]       tbl_data;
    logic              wr_req;
    logic [7:0]        wr_slave;
    logic [7:0]        wr_reg;
    logic [7:0]        wr_data;
    logic              wr_busy;
    logic              wr_done;
    logic              wr_nack;

    modport master (
        output tbl_addr, wr_req, wr_slave, wr_reg, wr_data,
        input  tbl_data, wr_busy, wr_done, wr_nack
    );

    modport slave (
        input  tbl_addr, wr_req, wr_slave, wr_reg, wr_data,
        output tbl_data, wr_busy, wr_done, wr_nack
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Power-up I2C register configuration: delay, then write each {slave, reg, data} table entry
// through the write engine with a fixed inter-write gap and bounded retries.
module i2c_cfg_sequencer #(
    parameter int N_ENTRIES = 11,
    parameter int ADDR_W    = 5,
    parameter int PWRUP_DLY = 91000000,
    parameter int GAP_DLY   = 400,
    parameter int MAX_RETRY = 3,
    parameter int WAIT_TMO  = 4096
) (
    input  logic                       i_clock_in,
    input  logic                       i_reset,
    input  logic                       i_start,
    i2c_cfg_sequencer_if.master        bus,
    output logic                       o_cfg_done,
    output logic                       o_cfg_err,
    output logic [ADDR_W-1:0]          o_err_idx,
    output logic [7:0]                 o_entry_cnt
);
    localparam int PW_W = (PWRUP_DLY > 0) ? $clog2(PWRUP_DLY + 1) : 1;
    localparam int GP_W = (GAP_DLY > 0)   ? $clog2(GAP_DLY + 1)   : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TM_W = (WAIT_TMO > 0)  ? $clog2(WAIT_TMO + 1)  : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t            r_state, w_next, w_after_pwrup, w_after_write;
    logic [PW_W-1:0]   r_pw_cnt;
    logic [GP_W-1:0]   r_gap_cnt;
    logic [TM_W-1:0]   r_tmo_cnt;
    logic [RT_W-1:0]   r_retry;
    logic [ADDR_W-1:0] r_idx, r_err_idx;
    logic [7:0]        r_entry_cnt, r_slave, r_reg, r_data;
    logic              w_last, w_ok, w_fail, w_tmo, w_can_retry;

    assign w_last        = (r_idx == ADDR_W'(N_ENTRIES - 1));
    assign w_tmo         = (r_tmo_cnt == TM_W'(WAIT_TMO - 1));
    assign w_ok          = bus.wr_done & ~bus.wr_nack;
    // A completion in the timeout cycle wins over the timeout itself.
    assign w_fail        = (bus.wr_done & bus.wr_nack) | (~bus.wr_done & w_tmo);
    assign w_can_retry   = (r_retry < RT_W'(MAX_RETRY));
    assign w_after_pwrup = (N_ENTRIES == 0) ? S_DONE : S_FETCH;
    assign w_after_write = (GAP_DLY == 0) ? S_FETCH : S_GAP;

    always_ff @(posedge i_clock_in) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (PWRUP_DLY == 0) ? w_after_pwrup : S_PWRUP;
            S_PWRUP: if (r_pw_cnt == PW_W'(PWRUP_DLY - 1)) w_next = w_after_pwrup;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_ISSUE;
            S_ISSUE: if (bus.wr_busy) w_next = S_WAIT;
            S_WAIT: begin
                if (w_ok)        w_next = w_last ? S_DONE : w_after_write;
                else if (w_fail) w_next = w_can_retry ? w_after_write : S_ERROR;
            end
            S_GAP:   if (r_gap_cnt == GP_W'(GAP_DLY - 1)) w_next = S_FETCH;
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        bus.wr_req = (r_state == S_ISSUE);
        o_cfg_done = (r_state == S_DONE);
        o_cfg_err  = (r_state == S_ERROR);
    end

    always_ff @(posedge i_clock_in) begin
        if (i_reset) begin
            r_pw_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_retry     <= '0;
            r_idx       <= '0;
            r_err_idx   <= '0;
            r_entry_cnt <= '0;
            r_slave     <= '0;
            r_reg       <= '0;
            r_data      <= '0;
        end else begin
            r_pw_cnt  <= (r_state == S_PWRUP) ? r_pw_cnt + 1'b1 : '0;
            r_gap_cnt <= (r_state == S_GAP)   ? r_gap_cnt + 1'b1 : '0;
            r_tmo_cnt <= (r_state == S_WAIT)  ? r_tmo_cnt + 1'b1 : '0;
            if (r_state == S_LOAD) {r_slave, r_reg, r_data} <= bus.tbl_data;
            if (r_state == S_WAIT) begin
                if (w_ok) begin
                    if (r_entry_cnt != 8'hFF) r_entry_cnt <= r_entry_cnt + 8'd1;
                    r_retry <= '0;
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end else if (w_fail) begin
                    if (w_can_retry) r_retry   <= r_retry + 1'b1;
                    else             r_err_idx <= r_idx;
                end
            end
        end
    end

    assign bus.tbl_addr = r_idx;
    assign bus.wr_slave = r_slave;
    assign bus.wr_reg   = r_reg;
    assign bus.wr_data  = r_data;
    assign o_err_idx    = r_err_idx;
    assign o_entry_cnt  = r_entry_cnt;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: engine BFM with scripted ACK/NACK/timeout per attempt, a random
// ROM table, and a table-walk reference model predicting writes, timing and final status.
module tb_i2c_cfg_sequencer;
    localparam int N = 3, AW = 5, PD = 10, GD = 4, MR = 2, TMO = 50;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, start0 = 1'b0;
    always #5 clk = ~clk;

    i2c_cfg_sequencer_if #(.ADDR_W(AW)) bus ();
    i2c_cfg_sequencer_if #(.ADDR_W(AW)) bus0 ();
    logic          cfg_done, cfg_err, done0, err0;
    logic [AW-1:0] err_idx, err_idx0;
    logic [7:0]    entry_cnt, entry_cnt0;

    i2c_cfg_sequencer #(.N_ENTRIES(N), .ADDR_W(AW), .PWRUP_DLY(PD), .GAP_DLY(GD),
                        .MAX_RETRY(MR), .WAIT_TMO(TMO)) dut (
        .i_clock_in(clk), .i_reset(rst), .i_start(start), .bus(bus),
        .o_cfg_done(cfg_done), .o_cfg_err(cfg_err), .o_err_idx(err_idx), .o_entry_cnt(entry_cnt));

    i2c_cfg_sequencer #(.N_ENTRIES(0), .ADDR_W(AW), .PWRUP_DLY(PD), .GAP_DLY(GD),
                        .MAX_RETRY(MR), .WAIT_TMO(TMO)) dut0 (
        .i_clock_in(clk), .i_reset(rst), .i_start(start0), .bus(bus0),
        .o_cfg_done(done0), .o_cfg_err(err0), .o_err_idx(err_idx0), .o_entry_cnt(entry_cnt0));

    assign bus0.tbl_data = '0;
    assign bus0.wr_busy  = 1'b0;
    assign bus0.wr_done  = 1'b0;
    assign bus0.wr_nack  = 1'b0;

    int n_tests = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] tbl [32];
    always @(posedge clk) bus.tbl_data <= tbl[bus.tbl_addr];

    // Per-attempt script: rsp 0=ACK, 1=NACK, 2=never completes; dly = cycles before accepting.
    int          sc_rsp[$], sc_dly[$], q_rsp[$], q_dly[$];
    logic [23:0] log_b[$], x_b[$];
    int          log_req[$], log_end[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int r, input int d);
        sc_rsp.push_back(r);
        sc_dly.push_back(d);
    endtask

    // Engine BFM
    initial begin : bfm
        logic [23:0] b;
        int d, r, l;
        bus.wr_busy = 1'b0; bus.wr_done = 1'b0; bus.wr_nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst && bus.wr_req) begin
                b = {bus.wr_slave, bus.wr_reg, bus.wr_data};
                log_b.push_back(b);
                log_req.push_back(cyc);
                d = (q_dly.size() > 0) ? q_dly.pop_front() : 0;
                r = (q_rsp.size() > 0) ? q_rsp.pop_front() : 0;
                for (int i = 0; i < d; i++) begin
                    @(posedge clk); #1;
                    chk("req_hold", {31'd0, bus.wr_req}, 32'd1);
                    chk("bytes_hold", {8'd0, bus.wr_slave, bus.wr_reg, bus.wr_data}, {8'd0, b});
                end
                bus.wr_busy = 1'b1;
                @(posedge clk); #1;
                chk("req_drop", {31'd0, bus.wr_req}, 32'd0);
                if (r == 2) begin
                    log_end.push_back(cyc - 1 + TMO);
                    repeat (3) @(posedge clk);
                    #1 bus.wr_busy = 1'b0;
                end else begin
                    l = $urandom_range(1, 8);
                    for (int i = 1; i < l; i++) begin
                        bus.wr_nack = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                    bus.wr_nack = (r == 1);
                    bus.wr_done = 1'b1;
                    chk("bytes_wait", {8'd0, bus.wr_slave, bus.wr_reg, bus.wr_data}, {8'd0, b});
                    log_end.push_back(cyc);
                    @(posedge clk); #1;
                    bus.wr_done = 1'b0; bus.wr_nack = 1'b0; bus.wr_busy = 1'b0;
                    @(posedge clk); #1;
                    bus.wr_done = 1'b1; bus.wr_nack = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    bus.wr_done = 1'b0; bus.wr_nack = 1'b0;
                end
            end
        end
    end

    task automatic run_scn(input bit rel_start);
        int e, tries, k, o, s, n, x_cnt, x_eidx;
        bit x_err;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        foreach (tbl[i]) tbl[i] = 24'($urandom);
        q_rsp = sc_rsp; q_dly = sc_dly;
        log_b.delete(); log_req.delete(); log_end.delete();
        // Reference: walk the table; each entry gets 1+MR attempts before the run errors out.
        e = 0; tries = 0; k = 0; x_cnt = 0; x_eidx = 0; x_err = 1'b0; x_b.delete();
        while (e < N && !x_err) begin
            o = (k < sc_rsp.size()) ? sc_rsp[k] : 0;
            k++;
            x_b.push_back(tbl[e]);
            if (o == 0) begin e++; tries = 0; x_cnt++; end
            else if (tries == MR) begin x_err = 1'b1; x_eidx = e; end
            else tries++;
        end
        start = 1'b1; s = cyc;
        if (rel_start) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
        end
        n = 0;
        while (!(cfg_done || cfg_err) && n < 3000) begin @(posedge clk); #1; n++; end
        chk("finish_bound", {31'd0, cfg_done | cfg_err}, 32'd1);
        repeat (80) @(posedge clk);
        #1;
        chk("cfg_done", {31'd0, cfg_done}, {31'd0, !x_err});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, x_err});
        chk("exclusive", {31'd0, cfg_done & cfg_err}, 32'd0);
        chk("err_idx", 32'(err_idx), 32'(x_eidx));
        chk("entry_cnt", 32'(entry_cnt), 32'(x_cnt));
        chk("n_writes", 32'(log_b.size()), 32'(x_b.size()));
        for (int i = 0; i < log_b.size() && i < x_b.size(); i++)
            chk($sformatf("bytes[%0d]", i), {8'd0, log_b[i]}, {8'd0, x_b[i]});
        if (log_req.size() > 0) chk("first_req_lat", 32'(log_req[0] - s), 32'(PD + 3));
        for (int i = 1; i < log_req.size(); i++)
            chk($sformatf("gap_lat[%0d]", i), 32'(log_req[i] - log_end[i-1]), 32'(GD + 3));
        start = 1'b0;
        sc_rsp.delete(); sc_dly.delete();
    endtask

    initial begin : main
        int n, s, x;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_req", {31'd0, bus.wr_req}, 32'd0);
        chk("rst_cnt_idx", {16'd0, entry_cnt, 3'd0, err_idx}, 32'd0);
        chk("rst_bytes", {8'd0, bus.wr_slave, bus.wr_reg, bus.wr_data}, 32'd0);
        chk("rst_addr", 32'(bus.tbl_addr), 32'd0);

        add(0, 0); add(0, 2); add(0, 1);                  // clean, START dropped mid-run
        run_scn(1'b1);
        add(0, 0); add(1, 0); add(0, 0); add(0, 0);      // single NACK on entry 1
        run_scn(1'b0);
        add(0, 0); add(0, 0); add(1, 0); add(1, 1); add(1, 0);  // entry 2 exhausts retries
        run_scn(1'b0);
        add(2, 0); add(2, 0); add(2, 0);                  // engine never completes
        run_scn(1'b0);
        add(0, 7); add(0, 0); add(0, 7);                  // slow accept
        run_scn(1'b0);
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 8; a++) begin
                x = $urandom_range(0, 9);
                add((x < 6) ? 0 : (x < 8) ? 1 : 2, $urandom_range(0, 3));
            end
            run_scn(1'b0);
        end

        // Reset while the sequencer is waiting on the engine
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        log_b.delete(); log_req.delete(); log_end.delete();
        q_rsp.delete(); q_dly.delete();
        q_rsp.push_back(0); q_rsp.push_back(2);
        start = 1'b1;
        n = 0;
        while (log_req.size() < 2 && n < 500) begin @(posedge clk); #1; n++; end
        chk("rst_reach_wait", 32'(log_req.size()), 32'd2);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_cnt", 32'(entry_cnt), 32'd1);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("wrst_req", {31'd0, bus.wr_req}, 32'd0);
        chk("wrst_cnt", 32'(entry_cnt), 32'd0);
        chk("wrst_flags", {30'd0, cfg_done, cfg_err}, 32'd0);
        chk("wrst_bytes", {8'd0, bus.wr_slave, bus.wr_reg, bus.wr_data}, 32'd0);
        chk("wrst_addr", 32'(bus.tbl_addr), 32'd0);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("wrst_idle", 32'(log_req.size()), 32'd2);

        // Empty table: straight to done after the power-up delay
        start0 = 1'b1; s = cyc; n = 0;
        while (!done0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("n0_lat", 32'(cyc - s), 32'(PD + 1));
        chk("n0_err", {31'd0, err0}, 32'd0);
        chk("n0_req", {31'd0, bus0.wr_req}, 32'd0);
        chk("n0_cnt", {16'd0, entry_cnt0, 3'd0, err_idx0}, 32'd0);
        chk("n0_bytes", {3'd0, bus0.tbl_addr, bus0.wr_slave, bus0.wr_reg, bus0.wr_data}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
